// File: rtl/neo_lb_ctrl.sv
// neo_lb_ctrl: line-buffer sequencer for a double-buffered sprite line buffer.
// One buffer pair is displayed (read, then cleared) while the other pair is
// rendered (sprite strips written). TMS0 swaps the roles at every scanline.
// Display FSM: loads address 0, then clocks both display buffers once every
// two pixel ticks for 384 pixels. Render FSM: loads the strip start address,
// then writes up to eight pixel pairs into the render pair.
// All sequencing advances only on ticks (CLK_EN_6MB high).
module neo_lb_ctrl (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       CLK_EN_6MB,
  input  logic       LINE_START,
  input  logic       ACTIVE_LINE,
  input  logic       SPR_REQ,
  input  logic [8:0] SPR_X,
  output logic       SPR_ACK,
  input  logic       PIX_VALID,
  input  logic [1:0] PIX_OPAQUE,
  output logic [3:0] WE,
  output logic [3:0] CK,
  output logic       LD1,
  output logic       LD2,
  output logic [7:0] LB_ADDR,
  output logic       SS1,
  output logic       SS2,
  output logic       TMS0,
  output logic       RENDER_BUSY
);

  typedef enum logic [1:0] {D_IDLE, D_LOAD, D_RUN} d_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_WRITE} r_state_t;

  d_state_t   d_state_q, d_state_d;
  r_state_t   r_state_q, r_state_d;
  logic [8:0] pix_cnt_q, pix_cnt_d;
  logic [2:0] pair_cnt_q, pair_cnt_d;
  logic       tms0_q, tms0_d;
  logic [7:0] lb_addr_q, lb_addr_d;
  logic [3:0] we_q, we_d;
  logic [3:0] ck_q, ck_d;
  logic       ld1_q, ld1_d;
  logic       ld2_q, ld2_d;
  logic       ack_q, ack_d;

  // Internal pulses, not yet mapped onto a physical pair
  logic       disp_ld, disp_ck;
  logic       rend_ld, rend_ck;
  logic [1:0] rend_we;

  // State and registered strobes; everything clears asynchronously on nRST
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      d_state_q  <= D_IDLE;
      r_state_q  <= R_IDLE;
      pix_cnt_q  <= '0;
      pair_cnt_q <= '0;
      tms0_q     <= 1'b0;
      lb_addr_q  <= '0;
      we_q       <= '0;
      ck_q       <= '0;
      ld1_q      <= 1'b0;
      ld2_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      d_state_q  <= d_state_d;
      r_state_q  <= r_state_d;
      pix_cnt_q  <= pix_cnt_d;
      pair_cnt_q <= pair_cnt_d;
      tms0_q     <= tms0_d;
      lb_addr_q  <= lb_addr_d;
      we_q       <= we_d;
      ck_q       <= ck_d;
      ld1_q      <= ld1_d;
      ld2_q      <= ld2_d;
      ack_q      <= ack_d;
    end
  end

  // Display FSM: pair swap at line start, address load, then 384-pixel readout
  always_comb begin
    d_state_d = d_state_q;
    pix_cnt_d = pix_cnt_q;
    tms0_d    = tms0_q;
    disp_ld   = 1'b0;
    disp_ck   = 1'b0;
    if (CLK_EN_6MB) begin
      if (LINE_START) begin
        tms0_d    = ~tms0_q;
        d_state_d = D_LOAD;
      end else begin
        case (d_state_q)
          D_LOAD: begin
            disp_ld   = 1'b1;
            pix_cnt_d = '0;
            d_state_d = D_RUN;
          end
          D_RUN: begin
            pix_cnt_d = pix_cnt_q + 9'd1;
            // Each buffer word holds a pixel pair, so advance on odd pixels
            disp_ck   = pix_cnt_q[0];
            if (pix_cnt_q == 9'd383) d_state_d = D_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Render FSM: strip address load (yields to display load), then 8 pair writes
  always_comb begin
    r_state_d  = r_state_q;
    pair_cnt_d = pair_cnt_q;
    rend_ld    = 1'b0;
    rend_ck    = 1'b0;
    rend_we    = 2'b00;
    if (CLK_EN_6MB) begin
      case (r_state_q)
        R_IDLE: begin
          if (SPR_REQ) r_state_d = R_LOAD;
        end
        R_LOAD: begin
          if (LINE_START) begin
            r_state_d = R_IDLE;
          end else if (d_state_q != D_LOAD) begin
            // LB_ADDR is shared; the display load owns it on its tick
            rend_ld    = 1'b1;
            pair_cnt_d = '0;
            r_state_d  = R_WRITE;
          end
        end
        R_WRITE: begin
          if (LINE_START) begin
            r_state_d = R_IDLE;
          end else if (PIX_VALID) begin
            rend_ck    = 1'b1;
            rend_we    = {PIX_OPAQUE[1], PIX_OPAQUE[0]};
            pair_cnt_d = pair_cnt_q + 3'd1;
            if (pair_cnt_q == 3'd7) r_state_d = R_IDLE;
          end
        end
        default: r_state_d = R_IDLE;
      endcase
    end
  end

  // Map pulses onto pairs: TMS0=0 renders top {TL,TR} and displays bottom
  always_comb begin
    we_d      = '0;
    ck_d      = '0;
    ld1_d     = 1'b0;
    ld2_d     = 1'b0;
    ack_d     = rend_ld;
    lb_addr_d = lb_addr_q;
    if (disp_ld)      lb_addr_d = 8'd0;
    else if (rend_ld) lb_addr_d = SPR_X[8:1];
    if (!tms0_q) begin
      we_d[3:2] = rend_we;
      ck_d[3:2] = {2{rend_ck}};
      ck_d[1:0] = {2{disp_ck}};
      ld2_d     = rend_ld;
      ld1_d     = disp_ld;
    end else begin
      we_d[1:0] = rend_we;
      ck_d[1:0] = {2{rend_ck}};
      ck_d[3:2] = {2{disp_ck}};
      ld1_d     = rend_ld;
      ld2_d     = disp_ld;
    end
  end

  assign WE          = we_q;
  assign CK          = ck_q;
  assign LD1         = ld1_q;
  assign LD2         = ld2_q;
  assign SPR_ACK     = ack_q;
  assign LB_ADDR     = lb_addr_q;
  assign TMS0        = tms0_q;
  assign SS1         = (d_state_q == D_RUN) && ACTIVE_LINE && !tms0_q;
  assign SS2         = (d_state_q == D_RUN) && ACTIVE_LINE && tms0_q;
  assign RENDER_BUSY = (r_state_q != R_IDLE);

endmodule
